// File: rtl/fmap_buf_pkg.sv
// Shared types and size helpers for the padded feature-map writer.
// Holds the sequencer state encoding and pad/depth derivations.
package fmap_buf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  function automatic int pad_dim(input int n);
    return n + 2;
  endfunction

  function automatic int fmap_depth(input int w, input int h,
                                    input int c);
    return (w + 2) * (h + 2) * c;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pad_coord_counter.sv
// Row/column/channel walker over the padded frame.
// Flags border positions and tracks the linear write address.
module pad_coord_counter
  import fmap_buf_pkg::*;
#(
  parameter int PAD_WIDTH    = 7,
  parameter int PAD_HEIGHT   = 7,
  parameter int OUT_CHANNELS = 3,
  parameter int DEPTH        = 147,
  parameter int AW           = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic          border_o,
  output logic          last_o,
  output logic [AW-1:0] addr_o
);

  localparam int RW  = cnt_w(PAD_HEIGHT);
  localparam int CLW = cnt_w(PAD_WIDTH);
  localparam int CHW = cnt_w(OUT_CHANNELS);

  logic [RW-1:0]  pr_q, pr_d;
  logic [CLW-1:0] pc_q, pc_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [AW-1:0]  addr_q, addr_d;

  logic ch_end, pc_end, pr_end;

  assign ch_end = (ch_q == CHW'(OUT_CHANNELS - 1));
  assign pc_end = (pc_q == CLW'(PAD_WIDTH - 1));
  assign pr_end = (pr_q == RW'(PAD_HEIGHT - 1));

  assign border_o = (pr_q == '0) || pr_end ||
                    (pc_q == '0) || pc_end;
  assign last_o   = (addr_q == AW'(DEPTH - 1));
  assign addr_o   = addr_q;

  // Address runs alongside the nested counters; it equals
  // (pr*PAD_WIDTH+pc)*OUT_CHANNELS+ch without multipliers.
  always_comb begin
    pr_d   = pr_q;
    pc_d   = pc_q;
    ch_d   = ch_q;
    addr_d = addr_q;
    if (clr_i) begin
      pr_d   = '0;
      pc_d   = '0;
      ch_d   = '0;
      addr_d = '0;
    end else if (adv_i) begin
      addr_d = last_o ? '0 : addr_q + AW'(1);
      if (!ch_end) begin
        ch_d = ch_q + CHW'(1);
      end else begin
        ch_d = '0;
        if (!pc_end) begin
          pc_d = pc_q + CLW'(1);
        end else begin
          pc_d = '0;
          pr_d = pr_end ? '0 : pr_q + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pr_q   <= '0;
      pc_q   <= '0;
      ch_q   <= '0;
      addr_q <= '0;
    end else begin
      pr_q   <= pr_d;
      pc_q   <= pc_d;
      ch_q   <= ch_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/padded_fmap_writer.sv
// Streams a feature map into a buffer with a one-pixel zero border.
// Define PADDED_FMAP_WRITER_RELU_EN to clamp negative samples to 0.
module padded_fmap_writer
  import fmap_buf_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OUT_CHANNELS = 3,
  parameter int IN_WIDTH     = 5,
  parameter int IN_HEIGHT    = 5,
  parameter int PAD_WIDTH    = pad_dim(IN_WIDTH),
  parameter int PAD_HEIGHT   = pad_dim(IN_HEIGHT),
  parameter int DEPTH        =
    fmap_depth(IN_WIDTH, IN_HEIGHT, OUT_CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic                     is_padding,
  output logic                     wr_en,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);

  state_t state_q, state_d;

  logic          issue, clr, border, last;
  logic [AW-1:0] addr;

  logic                  wr_en_q, pad_q, done_q;
  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] data_q, sample;

  pad_coord_counter #(
    .PAD_WIDTH   (PAD_WIDTH),
    .PAD_HEIGHT  (PAD_HEIGHT),
    .OUT_CHANNELS(OUT_CHANNELS),
    .DEPTH       (DEPTH),
    .AW          (AW)
  ) u_coord (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .adv_i   (issue),
    .border_o(border),
    .last_o  (last),
    .addr_o  (addr)
  );

`ifdef PADDED_FMAP_WRITER_RELU_EN
  assign sample = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
  assign sample = in_data;
`endif

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    issue    = 1'b0;
    clr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr = 1'b1;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (border) begin
          issue = 1'b1;
        end else begin
          in_ready = 1'b1;
          issue    = in_valid;
        end
        if (issue && last) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_en_q <= 1'b0;
      pad_q   <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= issue;
      pad_q   <= issue && border;
      done_q  <= issue && last;
      addr_q  <= issue ? addr : '0;
      data_q  <= (issue && !border) ? sample : '0;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign is_padding = pad_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);

endmodule
